keypad_pin_entry: RTL and testbench
===================================

Name: keypad_pin_entry

Overview:
Consumes the scanned 4-bit key code from the keypad scanner (0-9 digits, 10 = '*', 11 = '#', 12 = no key). Turns scan samples into single key-press events and collects a fixed-length PIN. Compares the PIN on '#' and drives unlock, failure and lockout status to the lock/display logic. Runs on the same clock as the scanner.

Parameters:
PIN_LEN, 4, number of digits in a PIN (1-8)
RELEASE_CYCLES, 8, consecutive no-key (12) samples that count as release; must exceed the 4-phase scan period
MAX_FAIL, 3, consecutive wrong PINs that trigger lockout
UNLOCK_CYCLES, 500, cycles unlocked stays high
LOCK_CYCLES, 1000, lockout duration in cycles
DEFAULT_PIN, 16'h1234, reset PIN, 4 bits BCD per digit, first digit in the MS nibble, width 4*PIN_LEN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
key_inp  in  4  scanner code: 0-9, 10 '*', 11 '#', 12 none; other values are treated as 12
key_strobe  out  1  one-cycle pulse per accepted key press
key_code  out  4  code of the last accepted key, valid while key_strobe = 1
digit_cnt  out  4  digits currently buffered (0..PIN_LEN)
unlocked  out  1  high in UNLOCK state
fail_pulse  out  1  one-cycle pulse on a wrong PIN
locked  out  1  high in LOCKOUT state
fail_cnt  out  2  consecutive failures so far

Behaviour:
- Reset (rst = 0 at an edge): state ENTRY; digit_cnt = 0; buffer = 0; stored PIN = DEFAULT_PIN; fail_cnt = 0; all pulse and status outputs 0; key_code = 12; release flag set (treated as released).
- Press detection:
  - The release counter counts consecutive samples with key_inp = 12 and saturates at RELEASE_CYCLES.
  - At RELEASE_CYCLES the release flag sets.
  - The first sample with key_inp != 12 while the flag is set accepts that code. The flag clears. key_strobe = 1 and key_code = code on the next cycle.
  - While the flag is clear, non-12 samples (including a different code) are ignored and reset the release counter.
  - Presses are detected in every state. The FSM decides whether each press has an effect.
- FSM acts in the cycle key_strobe = 1. States:
  - ENTRY:
    - A digit shifts into the buffer LS nibble and digit_cnt++ only if digit_cnt < PIN_LEN. Further digits are dropped with no error.
    - '*' clears the buffer and digit_cnt.
    - '#' moves to CHECK.
  - CHECK (1 cycle):
    - Match iff digit_cnt == PIN_LEN and buffer == stored PIN. On match: go to UNLOCK and set fail_cnt = 0.
    - Otherwise: fail_pulse = 1 next cycle and fail_cnt++. If the new fail_cnt == MAX_FAIL, go to LOCKOUT; else go to ENTRY.
    - The buffer and digit_cnt clear on exit in both cases.
  - UNLOCK:
    - unlocked = 1 and a timer counts UNLOCK_CYCLES, then the state returns to ENTRY.
    - '#' returns to ENTRY immediately (manual relock). Other keys are ignored.
  - LOCKOUT:
    - locked = 1 and all keys are ignored.
    - After LOCK_CYCLES the state returns to ENTRY with fail_cnt = 0.
- Latency: key accepted at sample edge T -> key_strobe at T+1 -> CHECK at T+2 -> unlocked or fail_pulse at T+3.
- Timers reset to 0 on state entry. Width is ceil(log2(max(UNLOCK_CYCLES, LOCK_CYCLES))) + 1.
- fail_cnt saturates at MAX_FAIL and never wraps.
- Reset mid-operation (any state, any timer value) returns to the reset values within one edge. A stored PIN changed by the optional feature also returns to DEFAULT_PIN.

Optional Feature:
Macro KEYPAD_PIN_CHANGE_EN.
- Defined:
  - '*' in UNLOCK enters a SET state. unlocked stays 1 and the unlock timer is paused.
  - Digits fill the buffer as in ENTRY; '*' clears it.
  - '#' with digit_cnt == PIN_LEN writes the buffer to the stored PIN and goes to ENTRY.
  - '#' with any other count discards the entry and goes to ENTRY with the PIN unchanged.
  - SET has no timeout.
- Undefined: no SET state; '*' in UNLOCK is ignored; the stored PIN is the constant DEFAULT_PIN.

Test Plan:
1. Bench parameters: RELEASE_CYCLES = 8, UNLOCK_CYCLES = 20, LOCK_CYCLES = 40. Release rst, feed the scan pattern 1,12,12,12 for 16 cycles, then 12 for 10 cycles -> exactly one key_strobe with key_code = 1 and digit_cnt = 1.
2. Press 1,2,3,4,# with releases -> unlocked rises 3 cycles after the '#' sample, stays high 20 cycles, then ENTRY; fail_cnt = 0.
3. Press 1,2,3,# -> fail_pulse for one cycle, fail_cnt = 1, unlocked stays 0. Repeat twice more -> locked = 1 for 40 cycles with keys ignored, then fail_cnt = 0.
4. Press 1,2,3,4,5,6 then # -> digit_cnt holds at 4 and the entry matches (extra digits dropped). Separately: 9,9,*,1,2,3,4,# -> unlocks.
5. Press 1,2,3,4,# then pulse rst low for 1 cycle during UNLOCK -> the next edge shows unlocked = 0, digit_cnt = 0, key_code = 12.
6. With KEYPAD_PIN_CHANGE_EN defined: unlock, press *,5,6,7,8,#, then 1,2,3,4,# -> fail_pulse; 5,6,7,8,# -> unlocked.

Source files
------------

// File: rtl/keypad_pin_entry.sv
// Keypad PIN entry: debounces scanner samples into key presses, collects and checks a PIN and
// drives unlock / fail / lockout status. Define KEYPAD_PIN_CHANGE_EN to allow changing the PIN.
module keypad_pin_entry #(
  parameter int unsigned          PIN_LEN        = 4,
  parameter int unsigned          RELEASE_CYCLES = 8,
  parameter int unsigned          MAX_FAIL       = 3,
  parameter int unsigned          UNLOCK_CYCLES  = 500,
  parameter int unsigned          LOCK_CYCLES    = 1000,
  parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN    = 16'h1234
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_key_inp,
  output logic       o_key_strobe,
  output logic [3:0] o_key_code,
  output logic [3:0] o_digit_cnt,
  output logic       o_unlocked,
  output logic       o_fail_pulse,
  output logic       o_locked,
  output logic [1:0] o_fail_cnt
);

  localparam int unsigned BufW   = 4 * PIN_LEN;
  localparam int unsigned TmrMax = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax) + 1;
  localparam int unsigned RelW   = $clog2(RELEASE_CYCLES + 1);

  localparam logic [3:0]      KeyStar    = 4'd10;
  localparam logic [3:0]      KeyHash    = 4'd11;
  localparam logic [3:0]      KeyNone    = 4'd12;
  localparam logic [3:0]      PinLen     = 4'(PIN_LEN);
  localparam logic [1:0]      MaxFail    = 2'(MAX_FAIL);
  localparam logic [RelW-1:0] RelCycles  = RelW'(RELEASE_CYCLES);
  localparam logic [TmrW-1:0] UnlockLast = TmrW'(UNLOCK_CYCLES - 1);
  localparam logic [TmrW-1:0] LockLast   = TmrW'(LOCK_CYCLES - 1);

`ifdef KEYPAD_PIN_CHANGE_EN
  typedef enum logic [2:0] {StEntry, StCheck, StUnlock, StLockout, StSet} state_e;
`else
  typedef enum logic [2:0] {StEntry, StCheck, StUnlock, StLockout} state_e;
`endif

  // Press detector
  logic [3:0]      r_key_smp;
  logic [RelW-1:0] r_rel_cnt;
  logic            r_rel_flag;
  logic            r_key_strobe;
  logic [3:0]      r_key_code;

  // Entry FSM
  state_e          r_state;
  logic [BufW-1:0] r_buf;
  logic [3:0]      r_digit_cnt;
  logic            r_unlocked;
  logic            r_fail_pulse;
  logic            r_locked;
  logic [1:0]      r_fail_cnt;
  logic [TmrW-1:0] r_tmr;

  logic [3:0]      w_key_norm;
  logic [RelW-1:0] w_rel_inc;
  logic [BufW-1:0] w_pin;
  logic [BufW-1:0] w_buf_nxt;
  logic [3:0]      w_cnt_nxt;
  logic            w_match;
  logic [1:0]      w_fail_nxt;
  logic            w_hash;

`ifdef KEYPAD_PIN_CHANGE_EN
  logic [BufW-1:0] r_pin;
  assign w_pin = r_pin;
`else
  assign w_pin = DEFAULT_PIN;
`endif

  assign w_key_norm = (i_key_inp > KeyNone) ? KeyNone : i_key_inp;
  assign w_rel_inc  = r_rel_cnt + 1'b1;
  assign w_match    = (r_digit_cnt == PinLen) && (r_buf == w_pin);
  assign w_fail_nxt = (r_fail_cnt == MaxFail) ? MaxFail : r_fail_cnt + 2'd1;
  assign w_hash     = r_key_strobe && (r_key_code == KeyHash);

  // Digit / '*' handling shared by ENTRY and SET; surplus digits are dropped silently.
  always_comb begin
    w_buf_nxt = r_buf;
    w_cnt_nxt = r_digit_cnt;
    if (r_key_strobe) begin
      if (r_key_code < KeyStar) begin
        if (r_digit_cnt < PinLen) begin
          w_buf_nxt = (r_buf << 4) | BufW'(r_key_code);
          w_cnt_nxt = r_digit_cnt + 4'd1;
        end
      end else if (r_key_code == KeyStar) begin
        w_buf_nxt = '0;
        w_cnt_nxt = '0;
      end
    end
  end

  // Input is registered first, so a key sampled at edge T strobes after edge T+1.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_key_smp    <= KeyNone;
      r_rel_cnt    <= '0;
      r_rel_flag   <= 1'b1;
      r_key_strobe <= 1'b0;
      r_key_code   <= KeyNone;
    end else begin
      r_key_smp    <= w_key_norm;
      r_key_strobe <= 1'b0;
      if (r_key_smp == KeyNone) begin
        if (r_rel_cnt != RelCycles) begin
          r_rel_cnt <= w_rel_inc;
          if (w_rel_inc == RelCycles) r_rel_flag <= 1'b1;
        end
      end else begin
        r_rel_cnt <= '0;
        if (r_rel_flag) begin
          r_rel_flag   <= 1'b0;
          r_key_strobe <= 1'b1;
          r_key_code   <= r_key_smp;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= StEntry;
      r_buf        <= '0;
      r_digit_cnt  <= '0;
      r_unlocked   <= 1'b0;
      r_fail_pulse <= 1'b0;
      r_locked     <= 1'b0;
      r_fail_cnt   <= '0;
      r_tmr        <= '0;
`ifdef KEYPAD_PIN_CHANGE_EN
      r_pin        <= DEFAULT_PIN;
`endif
    end else begin
      r_fail_pulse <= 1'b0;
      case (r_state)
        StEntry: begin
          r_buf       <= w_buf_nxt;
          r_digit_cnt <= w_cnt_nxt;
          if (w_hash) r_state <= StCheck;
        end
        StCheck: begin
          r_buf       <= '0;
          r_digit_cnt <= '0;
          r_tmr       <= '0;
          if (w_match) begin
            r_state    <= StUnlock;
            r_unlocked <= 1'b1;
            r_fail_cnt <= '0;
          end else begin
            r_fail_pulse <= 1'b1;
            r_fail_cnt   <= w_fail_nxt;
            if (w_fail_nxt == MaxFail) begin
              r_state  <= StLockout;
              r_locked <= 1'b1;
            end else begin
              r_state <= StEntry;
            end
          end
        end
        StUnlock: begin
          if (w_hash || (r_tmr == UnlockLast)) begin
            r_state    <= StEntry;
            r_unlocked <= 1'b0;
            r_tmr      <= '0;
`ifdef KEYPAD_PIN_CHANGE_EN
          end else if (r_key_strobe && (r_key_code == KeyStar)) begin
            // Timer holds its value while the new PIN is entered.
            r_state     <= StSet;
            r_buf       <= '0;
            r_digit_cnt <= '0;
`endif
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        StLockout: begin
          if (r_tmr == LockLast) begin
            r_state    <= StEntry;
            r_locked   <= 1'b0;
            r_fail_cnt <= '0;
            r_tmr      <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
`ifdef KEYPAD_PIN_CHANGE_EN
        StSet: begin
          if (w_hash) begin
            if (r_digit_cnt == PinLen) r_pin <= r_buf;
            r_state     <= StEntry;
            r_unlocked  <= 1'b0;
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_tmr       <= '0;
          end else begin
            r_buf       <= w_buf_nxt;
            r_digit_cnt <= w_cnt_nxt;
          end
        end
`endif
        default: r_state <= StEntry;
      endcase
    end
  end

  assign o_key_strobe = r_key_strobe;
  assign o_key_code   = r_key_code;
  assign o_digit_cnt  = r_digit_cnt;
  assign o_unlocked   = r_unlocked;
  assign o_fail_pulse = r_fail_pulse;
  assign o_locked     = r_locked;
  assign o_fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Bench for keypad_pin_entry: directed scenarios plus randomized PIN attempts checked against a
// key-press level model (digit queue, stored PIN digits, failure count).
module tb_keypad_pin_entry;

  localparam int PIN_LEN        = 4;
  localparam int RELEASE_CYCLES = 8;
  localparam int MAX_FAIL       = 3;
  localparam int UNLOCK_CYCLES  = 20;
  localparam int LOCK_CYCLES    = 40;
  localparam int MEntry = 0, MUnlock = 1, MSet = 2;
`ifdef KEYPAD_PIN_CHANGE_EN
  localparam bit PinChg = 1'b1;
`else
  localparam bit PinChg = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_inp;
  logic       key_strobe, unlocked, fail_pulse, locked;
  logic [3:0] key_code, digit_cnt;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [3:0] last_code = 4'd12;

  int exp_digits[$];
  int pin_digits[PIN_LEN];
  int exp_fail;
  int m_mode;

  keypad_pin_entry #(
    .PIN_LEN        (PIN_LEN),
    .RELEASE_CYCLES (RELEASE_CYCLES),
    .MAX_FAIL       (MAX_FAIL),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCK_CYCLES    (LOCK_CYCLES),
    .DEFAULT_PIN    (16'h1234)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_inp    (key_inp),
    .o_key_strobe (key_strobe),
    .o_key_code   (key_code),
    .o_digit_cnt  (digit_cnt),
    .o_unlocked   (unlocked),
    .o_fail_pulse (fail_pulse),
    .o_locked     (locked),
    .o_fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_strobe) begin
      strobe_cnt++;
      last_code = key_code;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    exp_digits.delete();
    pin_digits = '{1, 2, 3, 4};
    exp_fail   = 0;
    m_mode     = MEntry;
  endfunction

  function automatic bit model_match();
    if (exp_digits.size() != PIN_LEN) return 1'b0;
    for (int i = 0; i < PIN_LEN; i++) if (exp_digits[i] != pin_digits[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_key(input logic [3:0] c);
    if (m_mode == MEntry || m_mode == MSet) begin
      if (c < 4'd10) begin
        if (exp_digits.size() < PIN_LEN) exp_digits.push_back(int'(c));
      end else if (c == 4'd10) begin
        exp_digits.delete();
      end else if (c == 4'd11 && m_mode == MSet) begin
        if (exp_digits.size() == PIN_LEN)
          for (int i = 0; i < PIN_LEN; i++) pin_digits[i] = exp_digits[i];
        exp_digits.delete();
        m_mode = MEntry;
      end
    end else if (m_mode == MUnlock) begin
      if (c == 4'd10 && PinChg) begin
        m_mode = MSet;
        exp_digits.delete();
      end else if (c == 4'd11) begin
        m_mode = MEntry;
      end
    end
  endfunction

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      key_inp = 4'($urandom_range(12, 15));
      @(negedge clk);
    end
  endtask

  // One key press: held for a few samples with scanner noise, then released.
  task automatic press(input logic [3:0] code, input int hold);
    int s0;
    int h;
    s0 = strobe_cnt;
    h  = (hold > 0) ? hold : int'($urandom_range(1, 4));
    for (int i = 0; i < h; i++) begin
      key_inp = (i == 0) ? code : 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    gap(RELEASE_CYCLES + int'($urandom_range(0, 3)));
    check("strobe_count", strobe_cnt - s0, 1);
    check("key_code", last_code, code);
    model_key(code);
    check("digit_cnt", digit_cnt, exp_digits.size());
  endtask

  task automatic enter_digits(input int d0, input int d1, input int d2, input int d3);
    press(4'(d0), 0); press(4'(d1), 0); press(4'(d2), 0); press(4'(d3), 0);
  endtask

  // '#' in ENTRY; how: 0 wait for timeout, 1 manual relock, 2 leave unlocked.
  task automatic do_hash(input int how);
    bit match;
    int n;
    match = model_match();
    exp_digits.delete();
    key_inp = 4'd11;
    @(negedge clk);
    key_inp = 4'd12;
    check("pre_unlocked_1", unlocked, 1'b0);
    @(negedge clk);
    check("hash_strobe", key_strobe, 1'b1);
    check("pre_unlocked_2", unlocked, 1'b0);
    @(negedge clk);
    check("pre_fail_3", fail_pulse, 1'b0);
    @(negedge clk);
    check("outcome_digit_cnt", digit_cnt, 0);
    if (match) begin
      exp_fail = 0;
      check("unlocked", unlocked, 1'b1);
      check("fail_pulse_none", fail_pulse, 1'b0);
      check("fail_cnt_clr", fail_cnt, 0);
      m_mode = MUnlock;
      if (how == 0) begin
        n = 0;
        while (unlocked && n < 100) begin
          n++;
          @(negedge clk);
        end
        check("unlock_len", n, UNLOCK_CYCLES);
        m_mode = MEntry;
      end else if (how == 1) begin
        gap(10);
        check("unlock_hold", unlocked, 1'b1);
        key_inp = 4'd11;
        @(negedge clk);
        key_inp = 4'd12;
        check("relock_t1", unlocked, 1'b1);
        @(negedge clk);
        check("relock_t2", unlocked, 1'b1);
        @(negedge clk);
        check("relock_t3", unlocked, 1'b0);
        m_mode = MEntry;
      end
    end else begin
      exp_fail = exp_fail + 1;
      check("fail_pulse", fail_pulse, 1'b1);
      check("fail_cnt", fail_cnt, exp_fail);
      check("fail_unlocked", unlocked, 1'b0);
      if (exp_fail == MAX_FAIL) begin
        check("locked", locked, 1'b1);
        n = 0;
        while (locked && n < 200) begin
          n++;
          key_inp = (n < 20) ? 4'($urandom_range(0, 15)) : 4'd12;
          @(negedge clk);
        end
        check("lock_len", n, LOCK_CYCLES);
        exp_fail = 0;
        check("lock_fail_cnt", fail_cnt, 0);
        check("lock_digit_cnt", digit_cnt, 0);
      end else begin
        check("not_locked", locked, 1'b0);
        @(negedge clk);
        check("fail_pulse_1cyc", fail_pulse, 1'b0);
      end
      m_mode = MEntry;
    end
    if (how != 2 || !match) gap(RELEASE_CYCLES);
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    key_inp = 4'd12;
    @(negedge clk);
    rst = 1'b1;
    check("rst_unlocked", unlocked, 1'b0);
    check("rst_digit_cnt", digit_cnt, 0);
    check("rst_key_code", key_code, 4'd12);
    check("rst_locked", locked, 1'b0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_strobe", key_strobe, 1'b0);
    model_reset();
    gap(RELEASE_CYCLES);
  endtask

  initial begin
    int s0;
    int n;
    model_reset();
    rst     = 1'b0;
    key_inp = 4'd12;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("reset_strobe", key_strobe, 1'b0);
    check("reset_key_code", key_code, 4'd12);
    check("reset_digit_cnt", digit_cnt, 0);
    check("reset_unlocked", unlocked, 1'b0);
    check("reset_fail_pulse", fail_pulse, 1'b0);
    check("reset_locked", locked, 1'b0);
    check("reset_fail_cnt", fail_cnt, 0);

    // Scan pattern with a held key: exactly one press.
    s0 = strobe_cnt;
    for (int i = 0; i < 16; i++) begin
      key_inp = (i % 4 == 0) ? 4'd1 : 4'd12;
      @(negedge clk);
    end
    gap(10);
    check("scan_one_strobe", strobe_cnt - s0, 1);
    check("scan_key_code", last_code, 4'd1);
    model_key(4'd1);
    check("scan_digit_cnt", digit_cnt, 1);
    press(4'd10, 0);

    // Correct PIN, timeout back to ENTRY.
    enter_digits(1, 2, 3, 4);
    do_hash(0);

    // Three wrong PINs lead to lockout.
    for (int r = 0; r < 3; r++) begin
      press(4'd1, 0); press(4'd2, 0); press(4'd3, 0);
      do_hash(0);
    end

    // Surplus digits dropped; '*' clears a partial entry.
    enter_digits(1, 2, 3, 4);
    press(4'd5, 0); press(4'd6, 0);
    do_hash(1);
    press(4'd9, 0); press(4'd9, 0); press(4'd10, 0);
    enter_digits(1, 2, 3, 4);
    do_hash(0);

    // Reset while unlocked.
    enter_digits(1, 2, 3, 4);
    do_hash(2);
    do_reset();

    enter_digits(1, 2, 3, 4);
    do_hash(2);
    gap(RELEASE_CYCLES + 1);
`ifdef KEYPAD_PIN_CHANGE_EN
    press(4'd10, 1);
    check("set_unlocked", unlocked, 1'b1);
    for (int d = 5; d <= 8; d++) begin
      press(4'(d), 0);
      check("set_hold_unlocked", unlocked, 1'b1);
    end
    press(4'd11, 0);
    check("set_exit_unlocked", unlocked, 1'b0);
    enter_digits(1, 2, 3, 4);
    do_hash(0);
    enter_digits(5, 6, 7, 8);
    do_hash(0);
    // PIN returns to default after reset.
    do_reset();
    enter_digits(1, 2, 3, 4);
    do_hash(0);
`else
    press(4'd10, 1);
    n = 0;
    while (unlocked && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("star_ignored", unlocked, 1'b0);
    m_mode = MEntry;
    gap(RELEASE_CYCLES);
`endif

    // Randomized attempts.
    for (int it = 0; it < 16; it++) begin
      int len;
      if ($urandom_range(0, 3) == 0) begin
        press(4'($urandom_range(0, 9)), 0);
        press(4'd10, 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < PIN_LEN; k++) press(4'(pin_digits[k]), 0);
        if ($urandom_range(0, 3) == 0) press(4'($urandom_range(0, 9)), 0);
      end else begin
        len = $urandom_range(0, 6);
        for (int k = 0; k < len; k++) press(4'($urandom_range(0, 9)), 0);
      end
      if ($urandom_range(0, 7) == 0) do_reset();
      do_hash(int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
